// File: rtl/jellyvl_etherneco_synctimer_cmdgen.sv
// Sync-timer command generator: serialises {cmd, time, offset} as a byte stream,
// then measures the round trip until the returned frame ends or the wait times out.
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_IDLE | waiting for sync_start; frame register idle
// ST_SEND | frame bytes presented on m_cmd_tx_*, advancing on valid & ready
// ST_WAIT | frame sent; waiting for res_rx_end or timeout expiry
module jellyvl_etherneco_synctimer_cmdgen #(
  parameter int TIMER_WIDTH  = 64,
  parameter int OFFSET_WIDTH = 32,
  parameter int RTT_WIDTH    = 16,
  parameter int TIMEOUT      = 1000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [TIMER_WIDTH-1:0]  current_time,
  input  logic [OFFSET_WIDTH-1:0] offset,
  input  logic                    sync_start,
  input  logic                    sync_override,
  output logic                    sync_busy,
  output logic                    sync_drop,
  output logic [7:0]              m_cmd_tx_data,
  output logic                    m_cmd_tx_last,
  output logic                    m_cmd_tx_valid,
  input  logic                    m_cmd_tx_ready,
  input  logic                    res_rx_end,
  input  logic                    res_rx_error,
  output logic [RTT_WIDTH-1:0]    rtt,
  output logic                    rtt_valid,
  output logic                    rtt_timeout
);

  localparam int FRAME_BYTES = 1 + TIMER_WIDTH / 8 + OFFSET_WIDTH / 8;
  localparam int FRAME_BITS  = FRAME_BYTES * 8;
  localparam int CNT_WIDTH   = $clog2(FRAME_BYTES + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_WAIT
  } state_t;

  state_t                 state;
  state_t                 state_next;
  logic [FRAME_BITS-1:0]  frame;
  logic [CNT_WIDTH-1:0]   byte_cnt;
  logic [RTT_WIDTH-1:0]   rtt_cnt;
  logic [RTT_WIDTH-1:0]   rtt_cnt_inc;
  logic [RTT_WIDTH-1:0]   wait_tmr;
  logic                   tx_accept;
  logic                   tx_final;
  logic                   wait_expired;

  assign tx_accept    = (state == ST_SEND) && m_cmd_tx_ready;
  assign tx_final     = (byte_cnt == CNT_WIDTH'(1));
  assign wait_expired = (wait_tmr == '0);
  assign rtt_cnt_inc  = (&rtt_cnt) ? rtt_cnt : rtt_cnt + RTT_WIDTH'(1);

  assign m_cmd_tx_valid = (state == ST_SEND);
  assign m_cmd_tx_last  = (state == ST_SEND) && tx_final;
  assign m_cmd_tx_data  = frame[7:0];
  assign sync_busy      = (state != ST_IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (sync_start) state_next = ST_SEND;
      ST_SEND: if (tx_accept && tx_final) state_next = ST_WAIT;
      ST_WAIT: if (res_rx_end || wait_expired) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frame       <= '0;
      byte_cnt    <= '0;
      rtt_cnt     <= '0;
      wait_tmr    <= '0;
      rtt         <= '0;
      rtt_valid   <= 1'b0;
      rtt_timeout <= 1'b0;
      sync_drop   <= 1'b0;
    end else begin
      sync_drop   <= sync_start && (state != ST_IDLE);
      rtt_valid   <= 1'b0;
      rtt_timeout <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (sync_start) begin
            frame    <= {offset, current_time, 7'b0, sync_override};
            byte_cnt <= CNT_WIDTH'(FRAME_BYTES);
            rtt_cnt  <= '0;
          end
        end
        ST_SEND: begin
          rtt_cnt <= rtt_cnt_inc;
          if (tx_accept) begin
            frame    <= frame >> 8;
            byte_cnt <= byte_cnt - CNT_WIDTH'(1);
            if (tx_final) wait_tmr <= RTT_WIDTH'(TIMEOUT - 1);
          end
        end
        ST_WAIT: begin
          rtt_cnt <= rtt_cnt_inc;
          // a response arriving on the expiry cycle still counts as a response
          if (res_rx_end) begin
            if (!res_rx_error) begin
              rtt       <= rtt_cnt_inc;
              rtt_valid <= 1'b1;
            end
          end else if (wait_expired) begin
            rtt_timeout <= 1'b1;
          end else begin
            wait_tmr <= wait_tmr - RTT_WIDTH'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
